pick_sw_debounce: RTL and testbench



---
 rtl/pick_sw_debounce.sv | 57 +++++
 tb/tb_pick_sw_debounce.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/pick_sw_debounce.sv
// pick_sw_debounce: synchronise and debounce ten raw switches into the select and data words of pick, flagging each accepted change.
module pick_sw_debounce #(
  parameter int STABLE_CYCLES = 16,
  parameter int CNT_W = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] sw,
  input  logic       hold,
  output logic [1:0] y,
  output logic [1:0] x0,
  output logic [1:0] x1,
  output logic [1:0] x2,
  output logic [1:0] x3,
  output logic       chg,
  output logic [9:0] chg_mask
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
  logic [9:0] s1, s2, st, st_nx, mask_nx;
  logic [9:0][CNT_W-1:0] cnt, cnt_nx;
  always_comb begin
    st_nx = st;
    cnt_nx = cnt;
    mask_nx = '0;
    for (int i = 0; i < 10; i++) begin
      if (!hold && s2[i] != st[i] && cnt[i] == LAST) begin
        st_nx[i] = s2[i];
        cnt_nx[i] = '0;
        mask_nx[i] = 1'b1;
      end else if (!hold) begin
        cnt_nx[i] = (s2[i] != st[i]) ? cnt[i] + 1'b1 : '0;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
      st <= '0;
      cnt <= '0;
      chg_mask <= '0;
      chg <= 1'b0;
    end else begin
      s1 <= sw;
      s2 <= s1;
      st <= st_nx;
      cnt <= cnt_nx;
      chg_mask <= mask_nx;
      chg <= |mask_nx;
    end
  end
  assign y  = st[1:0];
  assign x0 = st[3:2];
  assign x1 = st[5:4];
  assign x2 = st[7:6];
  assign x3 = st[9:8];
endmodule

// File: tb/tb_pick_sw_debounce.sv
// tb_pick_sw_debounce: random and directed switch activity checked against a run-length model of the debouncer.
module tb_pick_sw_debounce;
  localparam int SC = 4;
  logic clk = 1'b0;
  logic rst_n;
  logic [9:0] sw;
  logic hold;
  logic [1:0] y, x0, x1, x2, x3;
  logic chg;
  logic [9:0] chg_mask;
  int tests = 0;
  int fails = 0;
  logic [9:0] m_sw1, m_sw2, m_st, m_mask;
  logic m_chg;
  int run [10];

  pick_sw_debounce #(.STABLE_CYCLES(SC), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .sw(sw), .hold(hold), .y(y), .x0(x0), .x1(x1),
    .x2(x2), .x3(x3), .chg(chg), .chg_mask(chg_mask)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // A bit is accepted once s2 has disagreed with the stable value on SC consecutive unheld edges.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_sw1 = '0; m_sw2 = '0; m_st = '0; m_mask = '0; m_chg = 1'b0;
        for (int i = 0; i < 10; i++) run[i] = 0;
      end else begin
        m_mask = '0;
        if (!hold) begin
          for (int i = 0; i < 10; i++) begin
            if (m_sw2[i] != m_st[i]) begin
              run[i] = run[i] + 1;
              if (run[i] == SC) begin
                m_st[i] = m_sw2[i];
                m_mask[i] = 1'b1;
                run[i] = 0;
              end
            end else run[i] = 0;
          end
        end
        m_chg = |m_mask;
        m_sw2 = m_sw1;
        m_sw1 = sw;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("model_words", {x3, x2, x1, x0, y}, m_st);
      chk("model_chg", {9'd0, chg}, {9'd0, m_chg});
      chk("model_mask", chg_mask, m_mask);
    end
  end

  initial begin
    rst_n = 1'b0; sw = 10'h3FF; hold = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("rst_words", {x3, x2, x1, x0, y}, 10'h000);
      chk("rst_chg", {9'd0, chg}, 10'h000);
    end
    rst_n = 1'b1;
    tick(5);
    chk("rst_rel_e5", {x3, x2, x1, x0, y}, 10'h000);
    tick(1);
    chk("rst_rel_e6", {x3, x2, x1, x0, y}, 10'h3FF);
    chk("rst_rel_chg", {9'd0, chg}, 10'h001);
    chk("rst_rel_mask", chg_mask, 10'h3FF);
    tick(1);
    chk("rst_rel_pulse", {9'd0, chg}, 10'h000);
    sw = '0;
    tick(8);
    sw = 10'b10_01_00_11_10;
    tick(5);
    chk("clean_e5_chg", {9'd0, chg}, 10'h000);
    tick(1);
    chk("clean_y", {8'd0, y}, 10'b10);
    chk("clean_x0", {8'd0, x0}, 10'b11);
    chk("clean_x1", {8'd0, x1}, 10'b00);
    chk("clean_x2", {8'd0, x2}, 10'b01);
    chk("clean_x3", {8'd0, x3}, 10'b10);
    chk("clean_mask", chg_mask, 10'b10_01_00_11_10);
    tick(1);
    chk("clean_pulse", {9'd0, chg}, 10'h000);
    sw = '0;
    tick(8);
    for (int k = 0; k < 4; k++) begin
      sw[0] = (k % 2 == 0);
      tick(1);
      chk("bounce_chg", {9'd0, chg}, 10'h000);
      tick(1);
      chk("bounce_chg", {9'd0, chg}, 10'h000);
    end
    sw[0] = 1'b1;
    tick(5);
    chk("bounce_e5", {9'd0, y[0]}, 10'h000);
    tick(1);
    chk("bounce_e6", {9'd0, y[0]}, 10'h001);
    sw = '0;
    tick(8);
    sw[5] = 1'b1;
    tick(3);
    sw[5] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      chk("glitch_x1", {8'd0, x1}, 10'h000);
      chk("glitch_chg", {9'd0, chg}, 10'h000);
    end
    sw[9] = 1'b1;
    tick(4);
    hold = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick(1);
      chk("hold_x3", {8'd0, x3}, 10'h000);
      chk("hold_chg", {9'd0, chg}, 10'h000);
    end
    hold = 1'b0;
    tick(1);
    chk("hold_rel1", {9'd0, x3[1]}, 10'h000);
    tick(1);
    chk("hold_rel2", {9'd0, x3[1]}, 10'h001);
    chk("hold_rel_chg", {9'd0, chg}, 10'h001);
    sw = '0;
    tick(8);
    chk("hold_back", {x3, x2, x1, x0, y}, 10'h000);
    sw[2] = 1'b1;
    tick(5);
    #2 rst_n = 1'b0;
    #1 chk("arst_words", {x3, x2, x1, x0, y}, 10'h000);
    chk("arst_chg", {9'd0, chg}, 10'h000);
    tick(1);
    rst_n = 1'b1;
    tick(5);
    chk("arst_e5", {9'd0, x0[0]}, 10'h000);
    tick(1);
    chk("arst_e6", {9'd0, x0[0]}, 10'h001);
    chk("arst_chg6", {9'd0, chg}, 10'h001);
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 2) == 0) sw = sw ^ 10'($urandom & $urandom & $urandom & $urandom);
      hold = ($urandom_range(0, 11) == 0);
      if (k % 700 == 350) begin
        #2 rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
      end else tick(1);
      if (k % 250 == 0) begin
        hold = 1'b0;
        tick(SC + 3);
      end
    end
    tick(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
